// File: rtl/hazard_unit.sv
// Pipeline hazard control for the 5-stage core: load-use and branch stall/flush,
// E-stage operand forwarding, a multi-cycle E-op sequencer and a stall-cycle counter.
module hazard_unit #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic                 ResultSrcE0,
    input  logic                 PCSrcE,
    input  logic                 MulDivE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 StallE,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 MulDivDoneE,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam int CW = $clog2(MC_LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_reg;
    logic [CW-1:0]        cnt_reg;
    logic [CNT_WIDTH-1:0] stall_count_reg;

    logic [4:0] rs_e [2];
    logic [1:0] fwd  [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    // M-stage result is younger than W, so it takes priority; x0 never forwards.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd[gi] = 2'b00;
                if (reset)
                    fwd[gi] = 2'b00;
                else if (RegWriteM && (RdM != 5'd0) && (RdM == rs_e[gi]))
                    fwd[gi] = 2'b10;
                else if (RegWriteW && (RdW != 5'd0) && (RdW == rs_e[gi]))
                    fwd[gi] = 2'b01;
            end
        end
    endgenerate

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

    logic in_idle;
    logic lw_hazard;
    logic branch_flush;
    logic load_stall;
    logic mc_start;
    logic mc_stall;

    assign in_idle      = (state_reg == IDLE);
    assign lw_hazard    = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // A taken branch kills whatever sits in E, so it overrides load-use and op start.
    assign branch_flush = in_idle && PCSrcE;
    assign load_stall   = in_idle && !PCSrcE && lw_hazard;
    assign mc_start     = in_idle && !PCSrcE && MulDivE;
    assign mc_stall     = mc_start || (state_reg == BUSY);

    assign StallF      = !reset && (load_stall || mc_stall);
    assign StallD      = !reset && (load_stall || mc_stall);
    assign StallE      = !reset && mc_stall;
    assign FlushD      = !reset && branch_flush;
    assign FlushE      = !reset && (branch_flush || load_stall);
    assign FlushM      = !reset && mc_stall;
    assign MulDivDoneE = !reset && (state_reg == DONE);
    assign StallCount  = stall_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            stall_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mc_start) begin
                        cnt_reg   <= CW'(MC_LATENCY - 2);
                        state_reg <= (MC_LATENCY > 2) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1))
                        state_reg <= DONE;
                end
                DONE: begin
                    // MulDivE here still belongs to the finishing op.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (StallF && (stall_count_reg != {CNT_WIDTH{1'b1}}))
                stall_count_reg <= stall_count_reg + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one instance with the default latency of 4 and
// one with latency 2 and a 2-bit stall counter, both driven by the same inputs.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic       ResultSrcE0 = 1'b0, PCSrcE = 1'b0, MulDivE = 1'b0;
    logic       RegWriteM = 1'b0, RegWriteW = 1'b0;

    logic        a_stallf, a_stalld, a_flushd, a_stalle, a_flushe, a_flushm, a_done;
    logic [1:0]  a_fae, a_fbe;
    logic [31:0] a_cnt;
    logic        b_stallf, b_stalld, b_flushd, b_stalle, b_flushe, b_flushm, b_done;
    logic [1:0]  b_fae, b_fbe;
    logic [1:0]  b_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MC_LATENCY(4), .CNT_WIDTH(32)) u4 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(a_stallf), .StallD(a_stalld), .FlushD(a_flushd), .StallE(a_stalle),
        .FlushE(a_flushe), .FlushM(a_flushm), .ForwardAE(a_fae), .ForwardBE(a_fbe),
        .MulDivDoneE(a_done), .StallCount(a_cnt)
    );

    hazard_unit #(.MC_LATENCY(2), .CNT_WIDTH(2)) u2 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(b_stallf), .StallD(b_stalld), .FlushD(b_flushd), .StallE(b_stalle),
        .FlushE(b_flushe), .FlushM(b_flushm), .ForwardAE(b_fae), .ForwardBE(b_fbe),
        .MulDivDoneE(b_done), .StallCount(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MulDivE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
    endtask

    // Checks the stall/flush/done group of the latency-4 instance as one packed word
    // {StallF, StallD, FlushD, StallE, FlushE, FlushM, MulDivDoneE}.
    task automatic chk_ctl4(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, a_stallf, a_stalld, a_flushd, a_stalle, a_flushe, a_flushm, a_done},
            {25'd0, exp});
    endtask

    task automatic chk_ctl2(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, b_stallf, b_stalld, b_flushd, b_stalle, b_flushe, b_flushm, b_done},
            {25'd0, exp});
    endtask

    initial begin
        clear_in();
        next_cycle();
        next_cycle();
        $display("step reset held");
        chk_ctl4("reset_ctl4", 7'b0000000);
        chk("reset_fwd", {30'd0, a_fae}, 32'd0);
        chk("reset_cnt4", a_cnt, 32'd0);
        chk("reset_cnt2", {30'd0, b_cnt}, 32'd0);

        reset = 1'b0;
        next_cycle();
        $display("step forward M on A, W on B");
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        RegWriteW = 1'b1; RdW = 5'd6; Rs2E = 5'd6;
        #1;
        chk("fwd_a_m", {30'd0, a_fae}, 32'd2);
        chk("fwd_b_w", {30'd0, a_fbe}, 32'd1);

        $display("step forward M priority over W");
        RdW = 5'd5; Rs2E = 5'd5;
        #1;
        chk("fwd_b_mprio", {30'd0, a_fbe}, 32'd2);

        $display("step forward x0 and disabled M write");
        RdM = 5'd0; Rs1E = 5'd0; RdW = 5'd9; Rs2E = 5'd5; RegWriteM = 1'b1;
        #1;
        chk("fwd_x0", {30'd0, a_fae}, 32'd0);
        RegWriteM = 1'b0; RdM = 5'd9; Rs1E = 5'd9;
        #1;
        chk("fwd_a_w_only", {30'd0, a_fae}, 32'd1);
        chk("fwd_b_none", {30'd0, a_fbe}, 32'd0);

        clear_in();
        next_cycle();
        $display("step load-use on Rs2D");
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd3;
        #1;
        chk_ctl4("lw_stall", 7'b1100100);
        next_cycle();
        clear_in();
        #1;
        $display("step after load-use");
        chk_ctl4("lw_one_cycle", 7'b0000000);
        chk("lw_cnt4", a_cnt, 32'd1);
        chk("lw_cnt2", {30'd0, b_cnt}, 32'd1);

        $display("step load with rd x0");
        ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        #1;
        chk_ctl4("lw_x0_none", 7'b0000000);

        next_cycle();
        clear_in();
        $display("step taken branch");
        PCSrcE = 1'b1;
        #1;
        chk_ctl4("branch_flush", 7'b0010100);

        next_cycle();
        $display("step branch with load-use");
        ResultSrcE0 = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
        #1;
        chk_ctl4("branch_over_lw", 7'b0010100);

        next_cycle();
        clear_in();
        #1;
        $display("step after branch");
        chk_ctl4("branch_one_cycle", 7'b0000000);
        chk("branch_cnt4", a_cnt, 32'd1);

        // Op held in E for four cycles; latency-2 instance sees two ops back to back.
        MulDivE = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            $display("step multicycle cycle %0d", c);
            if (c < 3) chk_ctl4($sformatf("mc4_c%0d", c), 7'b1101010);
            else       chk_ctl4("mc4_done", 7'b0000001);
            if (c == 0 || c == 2) chk_ctl2($sformatf("mc2_c%0d", c), 7'b1101010);
            else                  chk_ctl2($sformatf("mc2_c%0d", c), 7'b0000001);
            next_cycle();
        end
        MulDivE = 1'b0;
        #1;
        $display("step multicycle idle");
        chk_ctl4("mc4_idle", 7'b0000000);
        chk_ctl2("mc2_idle", 7'b0000000);
        chk("mc_cnt4", a_cnt, 32'd4);
        chk("mc_cnt2", {30'd0, b_cnt}, 32'd3);

        $display("step load-use at saturation");
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        next_cycle();
        clear_in();
        #1;
        chk("sat_cnt4", a_cnt, 32'd5);
        chk("sat_cnt2", {30'd0, b_cnt}, 32'd3);

        $display("step reset while busy");
        MulDivE = 1'b1;
        next_cycle();
        #1;
        chk_ctl4("busy_before_reset", 7'b1101010);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        MulDivE = 1'b0;
        #1;
        chk_ctl4("after_reset_ctl", 7'b0000000);
        chk("after_reset_cnt", a_cnt, 32'd0);
        next_cycle();
        #1;
        chk_ctl4("after_reset_idle", 7'b0000000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
